sv39_ptw_lite: RTL

Hardware page-table walker that produces the fill traffic consumed by the fully-associative SV39 TLB. It accepts a single translation miss, walks the in-memory SV39 page table through a simple request/grant/rvalid memory port, and emits one `tlb_update_t` per successful walk, or a page-fault indication. The block sits between the TLB miss logic and the data-cache read port in the MMU. It has one outstanding walk and one outstanding memory read at a time.

---
 rtl/sv39_ptw_lite_pkg.sv | 72 +++++++
 rtl/sv39_ptw_lite_pte_check.sv | 62 ++++++
 rtl/sv39_ptw_lite.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sv39_ptw_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Package : riscv / sv39_ptw_lite_pkg
//  Brief   : Shared types for the SV39 page-table walker: the architectural
//            PTE layout (riscv) plus the TLB fill record, walker state and
//            page-table level encodings (sv39_ptw_lite_pkg).
//  Revision: 1.0 - initial release
// ============================================================================

package riscv;
    localparam int unsigned VLEN = 64;

    // SV39 PTE with the Svnapot N bit and Svpbmt field in the top bits.
    typedef struct packed {
        logic        n;
        logic [1:0]  pbmt;
        logic [6:0]  reserved;
        logic [43:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;
endpackage

package sv39_ptw_lite_pkg;
    // The fill record carries the widest supported ASID; narrower ASIDs
    // are zero-extended into it.
    localparam int unsigned ASID_W_MAX = 16;

    typedef enum logic [1:0] {
        L1G = 2'd0,
        L2M = 2'd1,
        L4K = 2'd2
    } ptw_lvl_e;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_GNT    = 3'd1,
        WAIT_RVALID = 3'd2,
        DONE        = 3'd3,
        FLUSHING    = 3'd4
    } ptw_state_e;

    typedef struct packed {
        logic                  valid;
        logic                  is_1G;
        logic                  is_2M;
        logic [26:0]           vpn;
        logic [ASID_W_MAX-1:0] asid;
        riscv::pte_t           content;
    } tlb_update_t;

    // VPN slice indexing the page table at the given level.
    function automatic logic [8:0] vpn_slice(input logic [riscv::VLEN-1:0] va,
                                             input ptw_lvl_e lvl);
        logic [8:0] s;
        case (lvl)
            L1G:     s = va[38:30];
            L2M:     s = va[29:21];
            default: s = va[20:12];
        endcase
        return s;
    endfunction
endpackage

`default_nettype wire

// File: rtl/sv39_ptw_lite_pte_check.sv
`default_nettype none
// ============================================================================
//  Module  : sv39_ptw_lite_pte_check
//  Brief   : Combinational classification of one PTE at a given walk level:
//            fault, descend to the next level, or accept as a leaf (with the
//            leaf contents, NAPOT-adjusted when enabled).
//  Config  : SVNAPOT_EN - accept 64 KiB NAPOT 4K leaves.
//  Revision: 1.0 - initial release
// ============================================================================

module sv39_ptw_lite_pte_check
    import sv39_ptw_lite_pkg::*;
(
    input  riscv::pte_t pte_i,
    input  ptw_lvl_e    level_i,
`ifdef SVNAPOT_EN
    input  logic [3:0]  va_idx_i,     // vaddr[15:12], selects the 4K page in a NAPOT block
`endif
    output logic        fault_o,
    output logic        descend_o,
    output riscv::pte_t content_o
);

    logic leaf_ok;

    // Decode the PTE: invalid/reserved encodings fault, pointers descend,
    // leaves are checked for A bit, superpage alignment and the N bit.
    always_comb begin
        fault_o   = 1'b0;
        descend_o = 1'b0;
        leaf_ok   = 1'b0;
        content_o = pte_i;
        if (!pte_i.v || (!pte_i.r && pte_i.w)) begin
            fault_o = 1'b1;
        end else if (!pte_i.r && !pte_i.x) begin
            if (level_i == L4K) fault_o   = 1'b1;
            else                descend_o = 1'b1;
        end else begin
            leaf_ok = 1'b1;
            if (!pte_i.a)                                    leaf_ok = 1'b0;
            if ((level_i == L1G) && (pte_i.ppn[17:0] != '0)) leaf_ok = 1'b0;
            if ((level_i == L2M) && (pte_i.ppn[8:0]  != '0)) leaf_ok = 1'b0;
            if (pte_i.n) begin
`ifdef SVNAPOT_EN
                // A NAPOT 64 KiB page is filled as the single 4K page hit.
                if ((level_i == L4K) && (pte_i.ppn[3:0] == 4'b1000)) begin
                    content_o.ppn[3:0] = va_idx_i;
                    content_o.n        = 1'b0;
                end else begin
                    leaf_ok = 1'b0;
                end
`else
                leaf_ok = 1'b0;
`endif
            end
            fault_o = !leaf_ok;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sv39_ptw_lite.sv
`default_nettype none
// ============================================================================
//  Module  : sv39_ptw_lite
//  Brief   : Single-walk SV39 hardware page-table walker. Walks the table via
//            a req/gnt/rvalid read port and emits one TLB fill per successful
//            walk or a one-cycle page-fault pulse.
//  Config  : SVNAPOT_EN - accept 64 KiB NAPOT 4K leaves.
//  Revision: 1.0 - initial release
// ============================================================================

module sv39_ptw_lite
    import sv39_ptw_lite_pkg::*;
#(
    parameter int unsigned ASID_WIDTH = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   enable_translation_i,
    input  logic                   miss_i,
    input  logic [riscv::VLEN-1:0] miss_vaddr_i,
    input  logic [ASID_WIDTH-1:0]  asid_i,
    input  logic [43:0]            satp_ppn_i,
    output logic                   mem_req_o,
    output logic [55:0]            mem_addr_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [63:0]            mem_rdata_i,
    output tlb_update_t            update_o,
    output logic                   busy_o,
    output logic                   fault_o,
    output logic [riscv::VLEN-1:0] fault_vaddr_o
);

    ptw_state_e              state_q;
    ptw_lvl_e                level_q;
    logic [43:0]             ptr_q;
    logic [riscv::VLEN-1:0]  vaddr_q;
    logic [ASID_W_MAX-1:0]   asid_q;
    tlb_update_t             update_q;
    logic                    fault_q;
    logic [riscv::VLEN-1:0]  fault_vaddr_q;

    riscv::pte_t             w_pte;
    riscv::pte_t             w_content;
    logic                    w_fault;
    logic                    w_descend;

    assign w_pte = riscv::pte_t'(mem_rdata_i);

    sv39_ptw_lite_pte_check u_pte_check (
        .pte_i     (w_pte),
        .level_i   (level_q),
`ifdef SVNAPOT_EN
        .va_idx_i  (vaddr_q[15:12]),
`endif
        .fault_o   (w_fault),
        .descend_o (w_descend),
        .content_o (w_content)
    );

    assign mem_req_o     = (state_q == WAIT_GNT);
    assign mem_addr_o    = {ptr_q, vpn_slice(vaddr_q, level_q), 3'b000};
    assign busy_o        = (state_q != IDLE);
    assign update_o      = update_q;
    assign fault_o       = fault_q;
    assign fault_vaddr_o = fault_vaddr_q;

    // Walker FSM with registered fill/fault outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            level_q       <= L1G;
            ptr_q         <= '0;
            vaddr_q       <= '0;
            asid_q        <= '0;
            update_q      <= '0;
            fault_q       <= 1'b0;
            fault_vaddr_q <= '0;
        end else begin
            update_q.valid <= 1'b0;
            fault_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (miss_i && enable_translation_i && !flush_i) begin
                        vaddr_q <= miss_vaddr_i;
                        asid_q  <= ASID_W_MAX'(asid_i);
                        level_q <= L1G;
                        ptr_q   <= satp_ppn_i;
                        state_q <= WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    // A request granted in the flush cycle still returns data,
                    // so it must be swallowed before going idle.
                    if (flush_i)        state_q <= mem_gnt_i ? FLUSHING : IDLE;
                    else if (mem_gnt_i) state_q <= WAIT_RVALID;
                end
                WAIT_RVALID: begin
                    if (flush_i) begin
                        state_q <= mem_rvalid_i ? IDLE : FLUSHING;
                    end else if (mem_rvalid_i) begin
                        if (w_fault) begin
                            fault_q       <= 1'b1;
                            fault_vaddr_q <= vaddr_q;
                            state_q       <= IDLE;
                        end else if (w_descend) begin
                            ptr_q   <= w_pte.ppn;
                            level_q <= (level_q == L1G) ? L2M : L4K;
                            state_q <= WAIT_GNT;
                        end else begin
                            update_q <= '{valid:   1'b1,
                                          is_1G:   (level_q == L1G),
                                          is_2M:   (level_q == L2M),
                                          vpn:     vaddr_q[38:12],
                                          asid:    asid_q,
                                          content: w_content};
                            state_q  <= DONE;
                        end
                    end
                end
                // The fill is presented during DONE; a flush here simply
                // returns to idle along with the normal path.
                DONE: begin
                    state_q <= IDLE;
                end
                FLUSHING: begin
                    if (mem_rvalid_i) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
